seq_scan_ctrl: RTL and testbench

- Controller that feeds parallel words, one bit per cycle MSB-first, into a streaming Moore "1001"-class pattern detector.
- Counts overlapping pattern matches per word and reports the count and first-match position over a valid/ready result channel.
- Sits between a word-oriented producer and consumer; owns sequencing, history control and result reporting for the detector.

---
 rtl/seq_scan_pkg.sv | 7 +
 rtl/seq_pattern_det.sv | 31 +++
 rtl/seq_scan_ctrl.sv | 75 +++++++
 tb/tb_seq_scan_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared state encoding and default parameters for the scan controller
package seq_scan_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} scan_state_t;
  localparam int DEF_W = 8;
  localparam int DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1001;
endpackage

// File: rtl/seq_pattern_det.sv
// seq_pattern_det: streaming Moore pattern detector with saturating fill count
module seq_pattern_det #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic shift_en,
  input  logic din,
  output logic hit
);
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
  always_comb begin
    hist_d = clr ? '0 : shift_en ? {hist_q[PAT_LEN-2:0], din} : hist_q;
    fill_d = clr ? '0 : (shift_en && fill_q != FILL_W'(PAT_LEN)) ? fill_q + FILL_W'(1) : fill_q;
  end
  // fill saturates at PAT_LEN, so equality means "at least PAT_LEN bits seen"
  assign hit = (hist_q == PATTERN) && (fill_q == FILL_W'(PAT_LEN));
endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: scans words MSB-first through the detector and reports match count/first index
module seq_scan_ctrl import seq_scan_pkg::*; #(
  parameter int W = DEF_W,
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int CNT_W = 4,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_first
);
  scan_state_t state_q, state_d;
  logic [W-1:0] sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d, first_q, first_d, bit_k;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic hit, accept, last_bit, count_en;
  seq_pattern_det #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN)) u_det (
    .clk(clk),
    .reset_n(reset_n),
    .clr(clr && state_q == IDLE),
    .shift_en(state_q == SHIFT),
    .din(sh_q[W-1]),
    .hit(hit)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE && in_valid) ? SHIFT :
              (state_q == SHIFT && last_bit) ? DRAIN :
              (state_q == DRAIN) ? REPORT :
              (state_q == REPORT && out_ready) ? IDLE : state_q;
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == REPORT;
  end
  assign accept   = state_q == IDLE && in_valid;
  assign last_bit = idx_q == IDX_W'(W - 1);
  // the hit seen during a cycle belongs to the bit shifted at the end of the previous one
  assign count_en = hit && ((state_q == SHIFT && idx_q != '0) || state_q == DRAIN);
  assign bit_k    = (state_q == DRAIN) ? idx_q : idx_q - IDX_W'(1);
  always_comb begin
    sh_d    = accept ? in_data : (state_q == SHIFT) ? {sh_q[W-2:0], 1'b0} : sh_q;
    idx_d   = accept ? '0 : (state_q == SHIFT && !last_bit) ? idx_q + IDX_W'(1) : idx_q;
    cnt_d   = accept ? '0 : count_en ? cnt_q + CNT_W'(1) : cnt_q;
    first_d = accept ? '0 : (count_en && cnt_q == '0) ? bit_k : first_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end
  assign out_count = cnt_q;
  assign out_hit   = cnt_q != '0;
  assign out_first = first_q;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: randomized and directed checks against a bit-stream reference model
module tb_seq_scan_ctrl;
  localparam int W = 8, PAT_LEN = 4, CNT_W = 4, IDX_W = 3;
  localparam logic [PAT_LEN-1:0] PATTERN = 4'b1001;
  logic clk = 0, reset_n = 0, in_valid = 0, clr = 0, out_ready = 1;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_hit;
  logic [CNT_W-1:0] out_count;
  logic [IDX_W-1:0] out_first;
  int checks = 0, errors = 0;
  seq_scan_ctrl #(.W(W), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .clr(clr), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_hit(out_hit), .out_first(out_first)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction
  // reference model: the detector sees one long bit stream, broken only by clr/reset
  bit hq[$];
  int cyc = 0, t_acc = 0, e_cnt = 0, e_first = 0;
  bit busy = 0;
  int acc_cyc[$];
  function automatic void scan_word(input logic [W-1:0] d, output int c, output int f);
    c = 0;
    f = 0;
    for (int k = 0; k < W; k++) begin
      int v;
      hq.push_back(d[W-1-k]);
      if (hq.size() > PAT_LEN) void'(hq.pop_front());
      v = 0;
      foreach (hq[i]) v = v * 2 + int'(hq[i]);
      if (hq.size() == PAT_LEN && v == int'(PATTERN)) begin
        if (c == 0) f = k;
        c++;
      end
    end
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      busy = 0;
      hq.delete();
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_count", int'(out_count), 0);
      chk("rst_out_hit", int'(out_hit), 0);
      chk("rst_out_first", int'(out_first), 0);
    end else begin
      bit e_ov;
      e_ov = busy && (cyc - t_acc >= W + 2);
      chk("in_ready", int'(in_ready), int'(!busy));
      chk("out_valid", int'(out_valid), int'(e_ov));
      if (e_ov) begin
        chk("out_count", int'(out_count), e_cnt);
        chk("out_hit", int'(out_hit), int'(e_cnt != 0));
        chk("out_first", int'(out_first), e_first);
        if (out_ready) busy = 0;
      end else if (!busy) begin
        if (clr) hq.delete();
        if (in_valid) begin
          busy = 1;
          t_acc = cyc;
          acc_cyc.push_back(cyc);
          scan_word(in_data, e_cnt, e_first);
        end
      end
    end
  end
  task automatic send(input logic [W-1:0] d, output int rc, output int rf, output int rh, output int lat);
    @(posedge clk); #1;
    in_valid = 1; in_data = d; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = -1; rc = -1; rf = -1; rh = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i; rc = int'(out_count); rf = int'(out_first); rh = int'(out_hit);
        break;
      end
    end
    if (lat < 0) $display("FAIL send_timeout: got no out_valid expected within 40 cycles");
    @(posedge clk); #1;
  endtask
  initial begin
    int c, f, h, l, n;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    send(8'b1001_0010, c, f, h, l);
    chk("t1_count", c, 2); chk("t1_first", f, 3); chk("t1_hit", h, 1); chk("t1_latency", l, W + 2);
    send(8'b0000_0000, c, f, h, l);
    chk("t2_count", c, 0); chk("t2_hit", h, 0); chk("t2_first", f, 0);
    send(8'b0000_0100, c, f, h, l);
    chk("t3a_count", c, 0);
    send(8'b1000_0000, c, f, h, l);
    chk("t3b_count", c, 1); chk("t3b_first", f, 0);
    send(8'b0000_0100, c, f, h, l);
    @(posedge clk); #1 clr = 1;
    @(posedge clk); #1 clr = 0;
    send(8'b1000_0000, c, f, h, l);
    chk("t4_count_after_clr", c, 0);
    // backpressure
    @(posedge clk); #1;
    out_ready = 0; in_valid = 1; in_data = 8'b1001_0010;
    @(posedge clk); #1 in_valid = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_reached", int'(n < 40), 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1); chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_count", int'(out_count), 2); chk("bp_first", int'(out_first), 3);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", int'(in_ready), 1); chk("bp_idle_valid", int'(out_valid), 0);
    // reset while shifting bit index 4
    @(posedge clk); #1 in_valid = 1; in_data = 8'b1001_1001;
    @(posedge clk); #1 in_valid = 0;
    repeat (4) @(posedge clk);
    #1 reset_n = 0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1); chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_count", int'(out_count), 0); chk("mid_rst_hit", int'(out_hit), 0);
    chk("mid_rst_first", int'(out_first), 0);
    @(posedge clk); #1 reset_n = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("no_result_after_rst", int'(out_valid), 0);
    end
    send(8'b0001_0000, c, f, h, l);
    chk("post_rst_count", c, 0);
    // back-to-back
    @(posedge clk); #1;
    acc_cyc.delete();
    in_valid = 1; out_ready = 1;
    repeat (70) begin
      in_data = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (15) @(posedge clk);
    #1;
    chk("b2b_accepts", int'(acc_cyc.size() >= 6), 1);
    for (int i = 1; i < acc_cyc.size(); i++) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], W + 3);
    // random traffic, data biased toward pattern-rich words
    repeat (1500) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 2) == 0;
      in_data = ($urandom_range(0, 1) == 0) ? W'($urandom) : 8'b1001_0010 ^ W'(1 << $urandom_range(0, 7));
      clr = $urandom_range(0, 9) == 0;
      out_ready = $urandom_range(0, 1) == 1;
    end
    in_valid = 0; clr = 0; out_ready = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("final_idle", int'(in_ready), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
